// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- single-clock FIFO with registered read data and
// occupancy/status flags.
//
// Parameters
//   WIDTH     data word width (>= 1)
//   DEPTH     number of entries (power of two, >= 4)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   data_in       write data
//   we / re       write / read requests
//   data_out      read data, loaded on the edge a read is accepted
//   full, empty, almost_full, almost_empty
//                 decoded straight from the registered count
//   count         occupancy, 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   we,
    input  logic                   re,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Thresholds sized to the count so the flag compares are width-matched.
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // A read frees a slot on the same edge, so a write into a full FIFO is
    // still accepted when paired with a read. Requests are ignored in reset.
    assign rd_acc = re && !empty && !rst;
    assign wr_acc = we && (!full || rd_acc) && !rst;

    // Status flags: pure decode of the registered count, no extra latency.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Storage is deliberately not reset; pointers/count define validity.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            overflow  <= we && !wr_acc;
            underflow <= re && !rd_acc;
        end
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 16, number of storage entries; SHALL be a power of two and >= 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost-full threshold; SHALL satisfy 1 <= AF_LEVEL <= DEPTH.
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold; SHALL satisfy 0 <= AE_LEVEL < DEPTH.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  WIDTH  write data.
REQ-008 we  input  1  write request.
REQ-009 re  input  1  read request.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 almost_full  output  1  high when count >= AF_LEVEL.
REQ-014 almost_empty  output  1  high when count <= AE_LEVEL.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-016 overflow  output  1  one-cycle pulse on a rejected write.
REQ-017 underflow  output  1  one-cycle pulse on a rejected read.

Function
REQ-018 A write SHALL be accepted on a rising edge when we=1 and (full=0 or a read is accepted on the same edge); data_in SHALL be stored at the write pointer, and the write pointer SHALL advance.
REQ-019 A read SHALL be accepted on a rising edge when re=1 and empty=0; the entry at the read pointer SHALL be loaded into data_out on that edge (1-cycle latency, no fall-through), and the read pointer SHALL advance.
REQ-020 data_out SHALL hold its last value on every edge where no read is accepted.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 (modulo DEPTH); order SHALL be strict first-in, first-out.
REQ-022 count SHALL increment on a write-only accept, decrement on a read-only accept, and stay unchanged on both or neither.
REQ-023 Simultaneous we=1 and re=1 while empty: the write SHALL be accepted, the read rejected, underflow SHALL pulse, and count SHALL become 1.
REQ-024 Simultaneous we=1 and re=1 while full: both SHALL be accepted, count SHALL stay DEPTH, full SHALL stay 1, and overflow SHALL stay 0.
REQ-025 A write with we=1 while full and no accepted read SHALL not modify storage or pointers, and overflow SHALL be 1 for the following cycle.
REQ-026 A read with re=1 while empty SHALL not modify data_out or pointers, and underflow SHALL be 1 for the following cycle.
REQ-027 full, empty, almost_full and almost_empty SHALL be decoded from the registered count with no additional latency.
REQ-028 overflow and underflow SHALL be registered, and SHALL be high for exactly one cycle per rejected request.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for clk, set count=0, both pointers=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0 and underflow=0.
REQ-030 Asserting rst mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-031 While rst=1, we and re SHALL be ignored; the first accepted operation SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-032 Default parameters; reset, then write 16 words 0x01..0x10 -> count=16, full=1, almost_full has been 1 since count reached 14, overflow=0.
REQ-033 From full, write 0xAA with re=0 -> overflow pulses one cycle, count stays 16; the next 16 reads return 0x01..0x10 in order, with each word on data_out one edge after its read is accepted, and 0xAA never appears.
REQ-034 From empty, assert re for one cycle -> underflow pulses one cycle, data_out is unchanged, count stays 0.
REQ-035 Hold count=5, then drive we=1 and re=1 for 40 cycles with incrementing data -> count stays 5, output order is preserved across multiple pointer wraps, and no error pulse occurs.
REQ-036 Assert rst asynchronously between clock edges at count=9 -> count=0, empty=1 and data_out=0 before the next edge; a subsequent write/read of 0x5C returns 0x5C.
REQ-037 WIDTH=12, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1: fill then drain -> almost_empty=1 for count<=1, almost_full=1 for count>=6, full at count=8, and 12-bit data is intact.
